ma_stage: RTL and testbench

//  Memory-access stage: consumer of the EXMA pipeline register. Executes loads/stores

---
 rtl/ma_stage.sv | 208 ++++++++++++++++++++
 tb/tb_ma_stage.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ma_stage.sv
// ma_stage: memory-access pipeline stage.
// Takes the EXMA register contents, performs loads/stores over a req/ack
// data-memory port, formats load data, stalls upstream while an access is
// outstanding, forwards the MEM-stage value to EX and feeds the MAWB register.
// Optional build macro: MA_ALIGN_CHECK_EN (flags misaligned H/W accesses).
// i_MEM_Ctrl layout: [0] MA_RD, [1] MA_WR, [3:2] MA_SIZE (00 B, 01 H, 1x W), [4] MA_UNS.
module ma_stage #(
    parameter int WIDTH     = 32,
    parameter int ADDR_LSB  = 2,
    parameter int WB_WIDTH  = 2,
    parameter int MA_WIDTH  = 5,
    parameter int PC_WIDTH  = 32,
    parameter int RDSADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WB_WIDTH-1:0]   i_WB_Ctrl,
    input  logic [MA_WIDTH-1:0]   i_MEM_Ctrl,
    input  logic [WIDTH-1:0]      i_ALU_rslt,
    input  logic [WIDTH-1:0]      i_Rs2_val,
    input  logic [PC_WIDTH-1:0]   i_PC,
    input  logic [RDSADDR_W-1:0]  i_Rds_addr,
    input  logic                  i_MAWB_flush,
    input  logic                  i_MAWB_stall,
    output logic                  o_DMem_Req,
    output logic                  o_DMem_WE,
    output logic [WIDTH-1:0]      o_DMem_Addr,
    output logic [WIDTH-1:0]      o_DMem_WData,
    output logic [WIDTH/8-1:0]    o_DMem_BE,
    input  logic                  i_DMem_Ack,
    input  logic [WIDTH-1:0]      i_DMem_RData,
    output logic                  o_MA_Stall,
    output logic [WIDTH-1:0]      o_Data_To_EX,
    output logic [WB_WIDTH-1:0]   o_MAWB_WB,
    output logic [WIDTH-1:0]      o_MAWB_Data,
    output logic [PC_WIDTH-1:0]   o_MAWB_PC,
    output logic [RDSADDR_W-1:0]  o_MAWB_Rds_addr,
    output logic                  o_Misalign
);

    localparam int NBYTES = WIDTH / 8;

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_REQ  = 1'b1;

    logic [0:0]          state_q, state_d;
    logic                memop, isLoad, isStore, uns, sizeB, sizeH;
    logic [1:0]          sizeNorm;
    logic [ADDR_LSB-1:0] lsb, laneOff;
    logic                misaligned, startReq, ackNow;
    logic [NBYTES-1:0]   beNext;
    logic [WIDTH-1:0]    wdataNext, shifted, loadFmt, memResult, mawbData;

    logic [WIDTH-1:0]    reqAddr_q, reqWData_q;
    logic [NBYTES-1:0]   reqBE_q;
    logic                reqWE_q;
    logic [ADDR_LSB-1:0] fmtOff_q;
    logic [1:0]          fmtSize_q;
    logic                fmtUns_q;
    logic                heldValid_q;
    logic [WIDTH-1:0]    heldData_q;

    // Decode the memory control field; a simultaneous read+write counts as a read.
    assign memop    = i_MEM_Ctrl[0] | i_MEM_Ctrl[1];
    assign isLoad   = i_MEM_Ctrl[0];
    assign isStore  = i_MEM_Ctrl[1] & ~i_MEM_Ctrl[0];
    assign uns      = i_MEM_Ctrl[4];
    assign sizeB    = (i_MEM_Ctrl[3:2] == 2'b00);
    assign sizeH    = (i_MEM_Ctrl[3:2] == 2'b01);
    assign sizeNorm = sizeB ? 2'b00 : (sizeH ? 2'b01 : 2'b10);
    assign lsb      = i_ALU_rslt[ADDR_LSB-1:0];

`ifdef MA_ALIGN_CHECK_EN
    assign misaligned = memop & ((sizeH & lsb[0]) | (~sizeB & ~sizeH & (|lsb)));
`else
    assign misaligned = 1'b0;
`endif

    // A held result means the current EXMA op already completed, so it must not re-request.
    assign startReq   = (state_q == S_IDLE) & memop & ~heldValid_q & ~misaligned;
    assign ackNow     = (state_q == S_REQ) & i_DMem_Ack;
    assign o_MA_Stall = startReq | ((state_q == S_REQ) & ~i_DMem_Ack);
    assign o_DMem_Req = (state_q == S_REQ);

    // Byte-lane placement of the store data and the matching byte enables.
    always_comb begin
        laneOff   = '0;
        beNext    = '1;
        wdataNext = i_Rs2_val;
        if (sizeB) begin
            laneOff   = lsb;
            beNext    = NBYTES'(1) << lsb;
            wdataNext = {NBYTES{i_Rs2_val[7:0]}};
        end else if (sizeH) begin
            laneOff   = {lsb[ADDR_LSB-1:1], 1'b0};
            beNext    = NBYTES'(3) << {lsb[ADDR_LSB-1:1], 1'b0};
            wdataNext = {(WIDTH/16){i_Rs2_val[15:0]}};
        end
    end

    // Next-state logic: leave IDLE on a legal memop, return once memory acknowledges.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (startReq) state_d = S_REQ;
            S_REQ:   if (i_DMem_Ack) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Request registers are captured once on entry to REQ and stay stable until the ack.
    always_ff @(posedge clk) begin
        if (reset) begin
            reqAddr_q   <= '0;
            reqWData_q  <= '0;
            reqBE_q     <= '0;
            reqWE_q     <= 1'b0;
            fmtOff_q    <= '0;
            fmtSize_q   <= 2'b00;
            fmtUns_q    <= 1'b0;
        end else if (startReq) begin
            reqAddr_q   <= {i_ALU_rslt[WIDTH-1:ADDR_LSB], {ADDR_LSB{1'b0}}};
            reqWData_q  <= wdataNext;
            reqBE_q     <= beNext;
            reqWE_q     <= isStore;
            fmtOff_q    <= laneOff;
            fmtSize_q   <= sizeNorm;
            fmtUns_q    <= uns;
        end
    end

    assign o_DMem_Addr  = reqAddr_q;
    assign o_DMem_WData = reqWData_q;
    assign o_DMem_BE    = reqBE_q;
    assign o_DMem_WE    = reqWE_q;

    // Extract the addressed lane from the raw read word and sign/zero-extend it.
    always_comb begin
        shifted = i_DMem_RData >> {fmtOff_q, 3'b000};
        case (fmtSize_q)
            2'b00:   loadFmt = {{(WIDTH-8){~fmtUns_q & shifted[7]}}, shifted[7:0]};
            2'b01:   loadFmt = {{(WIDTH-16){~fmtUns_q & shifted[15]}}, shifted[15:0]};
            default: loadFmt = i_DMem_RData;
        endcase
    end

    // Keep load data that arrives while MAWB is stalled until MAWB can take it.
    always_ff @(posedge clk) begin
        if (reset) begin
            heldValid_q <= 1'b0;
            heldData_q  <= '0;
        end else if (i_MAWB_flush) begin
            heldValid_q <= 1'b0;
        end else if (ackNow & i_MAWB_stall) begin
            heldValid_q <= 1'b1;
            heldData_q  <= loadFmt;
        end else if (~i_MAWB_stall) begin
            heldValid_q <= 1'b0;
        end
    end

    assign memResult    = heldValid_q ? heldData_q : loadFmt;
    assign mawbData     = isLoad ? memResult : i_ALU_rslt;
    assign o_Data_To_EX = mawbData;

    // MAWB register: flush beats stall, stall holds, stalled or faulting memops become bubbles.
    always_ff @(posedge clk) begin
        if (reset || i_MAWB_flush) begin
            o_MAWB_WB       <= '0;
            o_MAWB_Data     <= '0;
            o_MAWB_PC       <= '0;
            o_MAWB_Rds_addr <= '0;
        end else if (i_MAWB_stall) begin
            o_MAWB_WB       <= o_MAWB_WB;
        end else if (o_MA_Stall || (misaligned && (state_q == S_IDLE))) begin
            o_MAWB_WB       <= '0;
            o_MAWB_Data     <= '0;
            o_MAWB_PC       <= '0;
            o_MAWB_Rds_addr <= '0;
        end else begin
            o_MAWB_WB       <= i_WB_Ctrl;
            o_MAWB_Data     <= mawbData;
            o_MAWB_PC       <= i_PC;
            o_MAWB_Rds_addr <= i_Rds_addr;
        end
    end

`ifdef MA_ALIGN_CHECK_EN
    logic misalign_q;

    // Flag a misaligned access for the cycle after it is seen in IDLE.
    always_ff @(posedge clk) begin
        if (reset) misalign_q <= 1'b0;
        else       misalign_q <= misaligned & (state_q == S_IDLE) & ~heldValid_q;
    end

    assign o_Misalign = misalign_q;
`else
    assign o_Misalign = 1'b0;
`endif

endmodule

// File: tb/tb_ma_stage.sv
// Testbench for ma_stage: table-driven memory transactions plus hand-written
// sequences for MAWB stall hold, reset mid-access, flush priority and alignment.
module tb_ma_stage;

   logic        clk;
   logic        reset;
   logic [1:0]  wbCtrl;
   logic [4:0]  memCtrl;
   logic [31:0] aluRslt, rs2Val, pcVal;
   logic [4:0]  rdsAddr;
   logic        mawbFlush, mawbStall;
   logic        dmemReq, dmemWE, dmemAck;
   logic [31:0] dmemAddr, dmemWData, dmemRData;
   logic [3:0]  dmemBE;
   logic        maStall;
   logic [31:0] dataToEx;
   logic [1:0]  mawbWB;
   logic [31:0] mawbData, mawbPC;
   logic [4:0]  mawbRds;
   logic        misalign;

   int checks = 0;
   int failures = 0;

   typedef struct {
      string       name;
      logic [4:0]  ctrl;
      logic [31:0] alu;
      logic [31:0] rs2;
      logic [31:0] rdata;
      int          ackDelay;
      logic [1:0]  wb;
      logic [31:0] expAddr;
      logic [3:0]  expBE;
      logic [31:0] expWData;
      logic        expWE;
      logic [31:0] expResult;
      int          expStall;
   } vec_t;

   vec_t vecs[$];

   ma_stage dut (
      .clk             (clk),
      .reset           (reset),
      .i_WB_Ctrl       (wbCtrl),
      .i_MEM_Ctrl      (memCtrl),
      .i_ALU_rslt      (aluRslt),
      .i_Rs2_val       (rs2Val),
      .i_PC            (pcVal),
      .i_Rds_addr      (rdsAddr),
      .i_MAWB_flush    (mawbFlush),
      .i_MAWB_stall    (mawbStall),
      .o_DMem_Req      (dmemReq),
      .o_DMem_WE       (dmemWE),
      .o_DMem_Addr     (dmemAddr),
      .o_DMem_WData    (dmemWData),
      .o_DMem_BE       (dmemBE),
      .i_DMem_Ack      (dmemAck),
      .i_DMem_RData    (dmemRData),
      .o_MA_Stall      (maStall),
      .o_Data_To_EX    (dataToEx),
      .o_MAWB_WB       (mawbWB),
      .o_MAWB_Data     (mawbData),
      .o_MAWB_PC       (mawbPC),
      .o_MAWB_Rds_addr (mawbRds),
      .o_Misalign      (misalign)
   );

   // Free-running clock, rising edge at odd multiples of 5.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Safety net so the run can never hang.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
      end
   endtask

   function automatic vec_t mk(input string name, input logic [4:0] ctrl, input logic [31:0] alu,
                               input logic [31:0] rs2, input logic [31:0] rdata, input int ackDelay,
                               input logic [1:0] wb, input logic [31:0] expAddr, input logic [3:0] expBE,
                               input logic [31:0] expWData, input logic expWE,
                               input logic [31:0] expResult, input int expStall);
      vec_t v;
      v.name = name; v.ctrl = ctrl; v.alu = alu; v.rs2 = rs2; v.rdata = rdata;
      v.ackDelay = ackDelay; v.wb = wb; v.expAddr = expAddr; v.expBE = expBE;
      v.expWData = expWData; v.expWE = expWE; v.expResult = expResult; v.expStall = expStall;
      return v;
   endfunction

   task automatic driveBubble();
      memCtrl = 5'd0; aluRslt = 32'd0; rs2Val = 32'd0; wbCtrl = 2'd0;
      pcVal = 32'd0; rdsAddr = 5'd0;
   endtask

   // Run one EXMA instruction through the stage, answering memory after ackDelay REQ cycles.
   task automatic applyStimulus(input vec_t v);
      int  stallCount;
      bit  isMem;
      isMem = v.ctrl[0] | v.ctrl[1];
      stallCount = 0;
      @(negedge clk);
      memCtrl = v.ctrl; aluRslt = v.alu; rs2Val = v.rs2; wbCtrl = v.wb;
      pcVal = v.alu + 32'h10; rdsAddr = v.alu[4:0] ^ 5'h1F;
      dmemAck = 1'b0; dmemRData = 32'd0;
      #1;
      checkOutput({v.name, " req before"}, 32'(dmemReq), 32'd0);
      if (maStall) stallCount++;
      if (isMem) begin
         for (int c = 0; c <= v.ackDelay; c++) begin
            @(negedge clk);
            checkOutput({v.name, " req"}, 32'(dmemReq), 32'd1);
            if (c == 0) begin
               checkOutput({v.name, " addr"}, dmemAddr, v.expAddr);
               checkOutput({v.name, " be"}, 32'(dmemBE), 32'(v.expBE));
               checkOutput({v.name, " we"}, 32'(dmemWE), 32'(v.expWE));
               if (v.expWE) checkOutput({v.name, " wdata"}, dmemWData, v.expWData);
               checkOutput({v.name, " mawb bubble"}, 32'(mawbWB), 32'd0);
            end
            if (c == v.ackDelay) begin
               dmemAck = 1'b1;
               dmemRData = v.rdata;
            end
            #1;
            if (maStall) stallCount++;
         end
         checkOutput({v.name, " addr at ack"}, dmemAddr, v.expAddr);
      end
      checkOutput({v.name, " fwd"}, dataToEx, v.expResult);
      @(negedge clk);
      dmemAck = 1'b0; dmemRData = 32'd0;
      driveBubble();
      #1;
      checkOutput({v.name, " stall cycles"}, 32'(stallCount), 32'(v.expStall));
      checkOutput({v.name, " mawb data"}, mawbData, v.expResult);
      checkOutput({v.name, " mawb wb"}, 32'(mawbWB), 32'(v.wb));
      checkOutput({v.name, " mawb pc"}, mawbPC, v.alu + 32'h10);
      checkOutput({v.name, " mawb rds"}, 32'(mawbRds), 32'(v.alu[4:0] ^ 5'h1F));
      checkOutput({v.name, " req after"}, 32'(dmemReq), 32'd0);
   endtask

   initial begin
      // ctrl = {UNS, SIZE[1:0], WR, RD}
      vecs.push_back(mk("LW",    5'b01001, 32'h100, 32'h0, 32'hDEADBEEF, 3, 2'b11, 32'h100, 4'b1111, 32'h0,        1'b0, 32'hDEADBEEF, 4));
      vecs.push_back(mk("LB",    5'b00001, 32'h103, 32'h0, 32'h80FFFFFF, 0, 2'b11, 32'h100, 4'b1000, 32'h0,        1'b0, 32'hFFFFFF80, 1));
      vecs.push_back(mk("LBU",   5'b10001, 32'h103, 32'h0, 32'h80FFFFFF, 1, 2'b11, 32'h100, 4'b1000, 32'h0,        1'b0, 32'h00000080, 2));
      vecs.push_back(mk("SH",    5'b00110, 32'h202, 32'h1234ABCD, 32'h0, 2, 2'b00, 32'h200, 4'b1100, 32'hABCDABCD, 1'b1, 32'h202,      3));
      vecs.push_back(mk("ADD",   5'b00000, 32'h55,  32'h0, 32'h0,        0, 2'b01, 32'h0,   4'b0000, 32'h0,        1'b0, 32'h55,       0));
      vecs.push_back(mk("LH",    5'b00101, 32'h106, 32'h0, 32'h80017FFF, 0, 2'b11, 32'h104, 4'b1100, 32'h0,        1'b0, 32'hFFFF8001, 1));
      vecs.push_back(mk("LHU",   5'b10101, 32'h104, 32'h0, 32'h1234F00F, 0, 2'b11, 32'h104, 4'b0011, 32'h0,        1'b0, 32'h0000F00F, 1));
      vecs.push_back(mk("SB",    5'b00010, 32'h101, 32'hA5, 32'h0,       0, 2'b00, 32'h100, 4'b0010, 32'hA5A5A5A5, 1'b1, 32'h101,      1));
      vecs.push_back(mk("SW",    5'b01010, 32'h300, 32'hCAFEF00D, 32'h0, 1, 2'b00, 32'h300, 4'b1111, 32'hCAFEF00D, 1'b1, 32'h300,      2));
      vecs.push_back(mk("RDWR",  5'b01011, 32'h400, 32'h0, 32'h11223344, 0, 2'b11, 32'h400, 4'b1111, 32'h0,        1'b0, 32'h11223344, 1));
      vecs.push_back(mk("LBpos", 5'b00001, 32'h101, 32'h0, 32'h00007F00, 0, 2'b11, 32'h100, 4'b0010, 32'h0,        1'b0, 32'h0000007F, 1));
`ifndef MA_ALIGN_CHECK_EN
      vecs.push_back(mk("LWmis", 5'b01001, 32'h101, 32'h0, 32'h0BADF00D, 0, 2'b11, 32'h100, 4'b1111, 32'h0,        1'b0, 32'h0BADF00D, 1));
`endif

      reset = 1'b1; mawbFlush = 1'b0; mawbStall = 1'b0; dmemAck = 1'b0; dmemRData = 32'd0;
      driveBubble();
      repeat (2) @(negedge clk);
      #1;
      checkOutput("reset req", 32'(dmemReq), 32'd0);
      checkOutput("reset we", 32'(dmemWE), 32'd0);
      checkOutput("reset be", 32'(dmemBE), 32'd0);
      checkOutput("reset addr", dmemAddr, 32'd0);
      checkOutput("reset wdata", dmemWData, 32'd0);
      checkOutput("reset mawb data", mawbData, 32'd0);
      checkOutput("reset mawb wb", 32'(mawbWB), 32'd0);
      checkOutput("reset misalign", 32'(misalign), 32'd0);
      reset = 1'b0;

      foreach (vecs[i]) applyStimulus(vecs[i]);

      // MAWB stalled when the ack arrives: data is held, no second request.
      @(negedge clk);
      memCtrl = 5'b01001; aluRslt = 32'h500; wbCtrl = 2'b11; pcVal = 32'h600; rdsAddr = 5'd7;
      mawbStall = 1'b1;
      #1;
      checkOutput("hold first stall", 32'(maStall), 32'd1);
      @(negedge clk);
      checkOutput("hold req", 32'(dmemReq), 32'd1);
      dmemAck = 1'b1; dmemRData = 32'hA5A50001;
      #1;
      checkOutput("hold ack stall", 32'(maStall), 32'd0);
      @(negedge clk);
      dmemAck = 1'b0; dmemRData = 32'd0;
      #1;
      checkOutput("hold no rereq", 32'(dmemReq), 32'd0);
      checkOutput("hold no stall", 32'(maStall), 32'd0);
      checkOutput("hold fwd", dataToEx, 32'hA5A50001);
      checkOutput("hold mawb frozen", mawbData, 32'd0);
      @(negedge clk);
      #1;
      checkOutput("hold no rereq 2", 32'(dmemReq), 32'd0);
      mawbStall = 1'b0;
      #1;
      checkOutput("hold release stall", 32'(maStall), 32'd0);
      @(negedge clk);
      driveBubble();
      #1;
      checkOutput("hold mawb data", mawbData, 32'hA5A50001);
      checkOutput("hold mawb wb", 32'(mawbWB), 32'd3);
      checkOutput("hold mawb pc", mawbPC, 32'h600);

      // Reset while a request is outstanding; the late ack must be ignored.
      @(negedge clk);
      memCtrl = 5'b00001; aluRslt = 32'h103; wbCtrl = 2'b11;
      @(negedge clk);
      checkOutput("rst mid req", 32'(dmemReq), 32'd1);
      reset = 1'b1;
      driveBubble();
      @(negedge clk);
      reset = 1'b0;
      dmemAck = 1'b1; dmemRData = 32'hFFFFFFFF;
      #1;
      checkOutput("rst req", 32'(dmemReq), 32'd0);
      checkOutput("rst stall", 32'(maStall), 32'd0);
      checkOutput("rst be", 32'(dmemBE), 32'd0);
      checkOutput("rst mawb data", mawbData, 32'd0);
      @(negedge clk);
      dmemAck = 1'b0; dmemRData = 32'd0;
      #1;
      checkOutput("rst ack ignored req", 32'(dmemReq), 32'd0);
      checkOutput("rst ack ignored wb", 32'(mawbWB), 32'd0);

      // Flush clears MAWB and wins over stall; stall alone holds.
      @(negedge clk);
      aluRslt = 32'h77; wbCtrl = 2'b01; mawbFlush = 1'b1;
      @(negedge clk);
      checkOutput("flush data", mawbData, 32'd0);
      mawbFlush = 1'b0;
      @(negedge clk);
      checkOutput("post flush data", mawbData, 32'h77);
      aluRslt = 32'h88; mawbFlush = 1'b1; mawbStall = 1'b1;
      @(negedge clk);
      checkOutput("flush over stall", mawbData, 32'd0);
      aluRslt = 32'h99; mawbFlush = 1'b0;
      @(negedge clk);
      checkOutput("stall holds", mawbData, 32'd0);
      mawbStall = 1'b0;
      @(negedge clk);
      checkOutput("stall release", mawbData, 32'h99);

`ifdef MA_ALIGN_CHECK_EN
      // Misaligned word load: flagged, no request, no stall, bubble into MAWB.
      @(negedge clk);
      memCtrl = 5'b01001; aluRslt = 32'h101; wbCtrl = 2'b11;
      #1;
      checkOutput("mis stall", 32'(maStall), 32'd0);
      @(negedge clk);
      driveBubble();
      #1;
      checkOutput("mis flag", 32'(misalign), 32'd1);
      checkOutput("mis req", 32'(dmemReq), 32'd0);
      checkOutput("mis mawb wb", 32'(mawbWB), 32'd0);
      @(negedge clk);
      #1;
      checkOutput("mis flag clears", 32'(misalign), 32'd0);
`else
      checkOutput("misalign tied", 32'(misalign), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
